fa_mux_1: RTL and testbench
===========================

Name: fa_mux_1

Overview:
- Mux-built full adder with a registered output stage.
- Each bit cell forms sum and carry only from 2:1 multiplexers, selected by the carry-in, rather than from a direct XOR/AND/OR expression.
- The WIDTH parameter chains cells into a ripple-carry adder.
- Used as the arithmetic leaf in datapath blocks. Outputs are registered so the block can sit directly on a pipeline boundary.

Parameters:
- WIDTH, default 1: operand width in bits. Legal range 1..64. The default is the single-bit full adder.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset. Assertion is immediate; deassertion is synchronised externally.
- in_valid  input  1  qualifies a, b and c on this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  1  carry-in into bit 0.
- sum  output  WIDTH  registered sum, (a+b+c) mod 2^WIDTH.
- carry  output  1  registered carry-out of the MSB cell.
- out_valid  output  1  high for exactly one cycle per accepted input.

Behaviour:
- Cell i is a mux-based full adder with p = a[i]^b[i] and ci = carry into cell i:
  - sum_i = ci ? ~p : p (2:1 mux on ci).
  - cout_i = p ? ci : a[i] (2:1 mux on p).
- ci for cell 0 is c; ci for cell i>0 is cout_(i-1).
- The carry chain is purely combinational within one cycle; no internal pipelining of the chain.
- Reset (rst_n=0, asynchronous): sum=0, carry=0, out_valid=0, held while rst_n is low.
- Rising clk with in_valid=1: sum and carry load the combinational result; out_valid=1. Latency is exactly 1 cycle.
- Rising clk with in_valid=0: sum and carry hold their previous values; out_valid=0.
- Back-to-back in_valid every cycle: one result per cycle; no stall and no backpressure.
- Reset asserted mid-operation: any pending result is discarded, outputs clear immediately, and the first valid output after release comes 1 cycle after the first accepted input.
- Width rule: the (WIDTH+1)-bit value {carry,sum} equals a+b+c exactly for all input combinations. No overflow flag beyond carry.
- X on inputs while in_valid=0 must not propagate into sum or carry.

Single-bit truth table (WIDTH=1), as a,b,c -> sum,carry:
- 000 -> 0,0
- 010 -> 1,0
- 100 -> 1,0
- 110 -> 0,1
- 001 -> 1,0
- 011 -> 0,1
- 101 -> 0,1
- 111 -> 1,1

Test Plan:
1. Reset: assert rst_n=0 mid-cycle with stale outputs present -> sum=0, carry=0, out_valid=0 immediately, without waiting for a clock edge.
2. Exhaustive WIDTH=1: drive all 8 (a,b,c) combinations in order 000,010,100,110,001,011,101,111, in_valid=1, one per cycle -> one cycle later sum/carry follow the truth table above; out_valid=1 throughout.
3. Hold: after a=1,b=1,c=1 (sum=1,carry=1), drop in_valid and drive a=0,b=0,c=0 -> sum=1, carry=1 persist; out_valid=0.
4. Full ripple at WIDTH=8: a=8'hFF, b=8'h00, c=1 -> sum=8'h00, carry=1. Then a=8'h80, b=8'h80, c=0 -> sum=8'h00, carry=1.
5. Random WIDTH=8: 1000 random in_valid-qualified vectors -> {carry,sum} equals a+b+c one cycle later; out_valid pulse count equals accepted-input count.
6. Reset mid-stream: pulse rst_n low between two valid inputs -> outputs clear; next valid input produces its correct result 1 cycle after acceptance.

Source files
------------

// File: rtl/fa_mux_1.sv
// Ripple-carry adder built only from 2:1 multiplexer cells, with a registered
// result stage so it can sit directly on a pipeline boundary.
module fa_mux_1 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             out_valid
);

  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   chain;
  logic [WIDTH-1:0] sum_next;

  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             valid_reg;

  assign chain[0] = c;

  // Each cell: sum muxed on its carry-in, carry-out muxed on propagate.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      assign prop[gi]     = a[gi] ^ b[gi];
      assign sum_next[gi] = chain[gi] ? ~prop[gi] : prop[gi];
      assign chain[gi+1]  = prop[gi] ? chain[gi] : a[gi];
    end
  endgenerate

  // Result only loads on accepted inputs, so idle-cycle operands never leak in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= in_valid;
      if (in_valid) begin
        sum_reg   <= sum_next;
        carry_reg <= chain[WIDTH];
      end
    end
  end

  assign sum       = sum_reg;
  assign carry     = carry_reg;
  assign out_valid = valid_reg;

endmodule

// File: tb/tb_fa_mux_1.sv
// Self-checking bench for fa_mux_1: exhaustive single-bit table, 8-bit ripple
// corners, randomized 8-bit traffic against an arithmetic model, reset cases.
module tb_fa_mux_1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       v1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic       s1, co1, ov1;

  logic       v8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [7:0] s8;
  logic       co8, ov8;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  fa_mux_1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .a(a1), .b(b1), .c(c1),
    .sum(s1), .carry(co1), .out_valid(ov1)
  );

  fa_mux_1 #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .a(a8), .b(b8), .c(c8),
    .sum(s8), .carry(co8), .out_valid(ov8)
  );

  typedef struct {
    logic a, b, c;
    logic exp_sum, exp_carry;
  } vec1_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec1_t tbl[8];
    logic [8:0] exp9, held9;
    logic [8:0] pend9;
    bit         v;
    int         accepted, pulses;

    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Power-on reset state
    #1;
    check("reset_sum1", 64'(s1), 64'd0);
    check("reset_carry1", 64'(co1), 64'd0);
    check("reset_ov1", 64'(ov1), 64'd0);
    check("reset_sum8", 64'(s8), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Exhaustive single-bit truth table, back-to-back
    for (int i = 0; i < 8; i++) begin
      v1 = 1'b1; a1 = tbl[i].a; b1 = tbl[i].b; c1 = tbl[i].c;
      step();
      check($sformatf("tt%0d%0d%0d_sum", tbl[i].a, tbl[i].b, tbl[i].c), 64'(s1), 64'(tbl[i].exp_sum));
      check($sformatf("tt%0d%0d%0d_carry", tbl[i].a, tbl[i].b, tbl[i].c), 64'(co1), 64'(tbl[i].exp_carry));
      check($sformatf("tt%0d_ov", i), 64'(ov1), 64'd1);
    end

    // Hold with idle operands after 1+1+1
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    step();
    check("hold_sum1", 64'(s1), 64'd1);
    check("hold_carry1", 64'(co1), 64'd1);
    check("hold_ov1", 64'(ov1), 64'd0);

    // Asynchronous reset mid-cycle with stale outputs present
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_sum1", 64'(s1), 64'd0);
    check("async_rst_carry1", 64'(co1), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Full ripple corners at WIDTH=8
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
    step();
    check("ripple_ff_sum", 64'(s8), 64'h00);
    check("ripple_ff_carry", 64'(co8), 64'd1);
    check("ripple_ff_ov", 64'(ov8), 64'd1);
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
    step();
    check("ripple_80_sum", 64'(s8), 64'h00);
    check("ripple_80_carry", 64'(co8), 64'd1);
    v8 = 1'b0;
    step();
    check("ripple_idle_ov", 64'(ov8), 64'd0);

    // Randomized traffic against plain arithmetic
    held9 = {co8, s8};
    accepted = 0;
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      v8 = v;
      exp9 = 9'(a8) + 9'(b8) + 9'(c8);
      if (v) begin
        accepted++;
        held9 = exp9;
      end
      step();
      if (ov8) pulses++;
      check($sformatf("rnd%0d_ov", i), 64'(ov8), 64'(v));
      check($sformatf("rnd%0d_sum", i), 64'({co8, s8}), 64'(held9));
    end
    check("rnd_pulse_count", 64'(pulses), 64'(accepted));

    // Reset between two valid inputs
    v8 = 1'b1; a8 = 8'h3C; b8 = 8'h5A; c8 = 1'b1;
    step();
    check("mid_pre_sum", 64'({co8, s8}), 64'(9'h097));
    a8 = 8'hC8; b8 = 8'h64; c8 = 1'b0;
    pend9 = 9'(a8) + 9'(b8) + 9'(c8);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", 64'({co8, s8}), 64'd0);
    check("mid_rst_ov", 64'(ov8), 64'd0);
    @(posedge clk); #1;
    check("mid_rst_held", 64'({co8, s8}), 64'd0);
    rst_n = 1'b1;
    v8 = 1'b1;
    step();
    check("mid_post_sum", 64'({co8, s8}), 64'(pend9));
    check("mid_post_ov", 64'(ov8), 64'd1);
    v8 = 1'b0;
    step();
    check("mid_post_idle_ov", 64'(ov8), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
